// File: rtl/bus_decoder.sv
// bus_decoder: N-region data-bus decoder and wait-state access sequencer (optional DEC_BUS_ERR_EN unmapped-address errors)
module bus_decoder #(
  parameter int                     DATA_W      = 32,
  parameter int                     ADDR_W      = 32,
  parameter int                     N_REGIONS   = 3,
  parameter logic [ADDR_W-1:0]      REGION_SIZE = 'h800,
  parameter logic [4*N_REGIONS-1:0] WAIT_STATES = 12'h210,
  parameter logic [ADDR_W-1:0]      ADDR_LIMIT  = 'h2000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req,
  input  logic [ADDR_W-1:0]           addr,
  input  logic                        we,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [N_REGIONS*DATA_W-1:0] rdata_i,
  output logic [N_REGIONS-1:0]        sel_o,
  output logic [N_REGIONS-1:0]        we_o,
  output logic [ADDR_W-1:0]           addr_o,
  output logic [DATA_W-1:0]           wdata_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        ack,
  output logic                        err,
  output logic                        busy
);
  localparam int RW = N_REGIONS > 1 ? $clog2(N_REGIONS) : 1;
  localparam int SH = $clog2(REGION_SIZE);
`ifdef DEC_BUS_ERR_EN
  localparam logic BUS_ERR_EN = 1'b1;
`else
  localparam logic BUS_ERR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t               r_state;
  logic [RW-1:0]        r_region;
  logic [3:0]           r_cnt;
  logic                 r_we;
  logic [ADDR_W-1:0]    w_idx;
  logic [RW-1:0]        w_region;
  logic [3:0]           w_ws;
  logic [N_REGIONS-1:0] w_onehot;
  logic                 w_bad;
  // Region decode with the last region absorbing every address above the map
  always_comb begin
    w_idx    = addr >> SH;
    w_region = (w_idx >= ADDR_W'(N_REGIONS - 1)) ? RW'(N_REGIONS - 1) : w_idx[RW-1:0];
    w_ws     = WAIT_STATES[4*w_region +: 4];
    w_onehot = N_REGIONS'(1) << w_region;
    w_bad    = BUS_ERR_EN && (addr >= ADDR_LIMIT);
  end
  assign busy = r_state != IDLE;
  // Access FSM: accept in IDLE, count wait states in ACCESS, acknowledge in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_region <= '0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      sel_o    <= '0;
      we_o     <= '0;
      addr_o   <= '0;
      wdata_o  <= '0;
      rdata_o  <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req) begin
          addr_o   <= addr;
          wdata_o  <= wdata;
          r_we     <= we;
          r_region <= w_region;
          r_cnt    <= w_bad ? 4'd0 : w_ws;
          if (w_bad) begin
            r_state <= DONE;
            ack     <= 1'b1;
            err     <= 1'b1;
            rdata_o <= '0;
          end else begin
            r_state <= ACCESS;
            sel_o   <= w_onehot;
            we_o    <= (we && w_ws == 4'd0) ? w_onehot : '0;
          end
        end
        ACCESS: if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
          we_o  <= (r_we && r_cnt == 4'd1) ? sel_o : '0;
        end else begin
          r_state <= DONE;
          sel_o   <= '0;
          we_o    <= '0;
          rdata_o <= r_we ? '0 : rdata_i[r_region*DATA_W +: DATA_W];
          ack     <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          ack     <= 1'b0;
          err     <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: directed-vector bench for bus_decoder (expectations follow DEC_BUS_ERR_EN when defined)
module tb_bus_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [95:0] rdata_i;
  logic [2:0]  sel_o;
  logic [2:0]  we_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_o;
  logic        ack;
  logic        err;
  logic        busy;
  int          n_vec = 0;
  int          n_err = 0;
  bus_decoder dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .we(we), .wdata(wdata),
    .rdata_i(rdata_i), .sel_o(sel_o), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .rdata_o(rdata_o), .ack(ack), .err(err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, ".sel"}, 64'(sel_o), 64'd0);
    chk({tag, ".we_o"}, 64'(we_o), 64'd0);
    chk({tag, ".ack"}, 64'(ack), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d,
                     input int nacc, input logic [2:0] es, input logic [31:0] erd, input logic ee);
    addr  = a;
    we    = w;
    wdata = d;
    req   = 1'b1;
    step();
    addr  = ~a;
    wdata = ~d;
    we    = ~w;
    for (int k = 1; k <= nacc; k++) begin
      chk({tag, ".sel"}, 64'(sel_o), 64'(es));
      chk({tag, ".we_o"}, 64'(we_o), 64'((w && k == nacc) ? es : 3'b000));
      chk({tag, ".ack_early"}, 64'(ack), 64'd0);
      chk({tag, ".busy"}, 64'(busy), 64'd1);
      step();
    end
    chk({tag, ".ack"}, 64'(ack), 64'd1);
    chk({tag, ".err"}, 64'(err), 64'(ee));
    chk({tag, ".sel_done"}, 64'(sel_o), 64'd0);
    chk({tag, ".we_done"}, 64'(we_o), 64'd0);
    chk({tag, ".rdata"}, 64'(rdata_o), 64'(erd));
    chk({tag, ".addr_o"}, 64'(addr_o), 64'(a));
    chk({tag, ".wdata_o"}, 64'(wdata_o), 64'(d));
    req = 1'b0;
    step();
    chk_idle({tag, ".after"});
  endtask
  initial begin
    reset   = 1'b1;
    req     = 1'b0;
    addr    = '0;
    we      = 1'b0;
    wdata   = '0;
    rdata_i = {32'hCAFEF00D, 32'h0BADF00D, 32'hDEADBEEF};
    step();
    step();
    chk_idle("rst");
    chk("rst.addr_o", 64'(addr_o), 64'd0);
    chk("rst.wdata_o", 64'(wdata_o), 64'd0);
    chk("rst.rdata", 64'(rdata_o), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    reset = 1'b0;
    step();
    run("rd0", 32'h7FC, 1'b0, 32'h0, 1, 3'b001, 32'hDEADBEEF, 1'b0);
    run("wr1", 32'h800, 1'b1, 32'h12345678, 2, 3'b010, 32'h0, 1'b0);
    run("rd2", 32'h1FFC, 1'b0, 32'h0, 3, 3'b100, 32'hCAFEF00D, 1'b0);
    run("rd1_top", 32'hFFC, 1'b0, 32'h0, 2, 3'b010, 32'h0BADF00D, 1'b0);
`ifdef DEC_BUS_ERR_EN
    run("wr_unmapped", 32'h2000, 1'b1, 32'hA5A5A5A5, 0, 3'b000, 32'h0, 1'b1);
    run("rd_unmapped", 32'h3000, 1'b0, 32'h0, 0, 3'b000, 32'h0, 1'b1);
`else
    run("wr_above", 32'h2000, 1'b1, 32'hA5A5A5A5, 3, 3'b100, 32'h0, 1'b0);
    run("rd_above", 32'h3000, 1'b0, 32'h0, 3, 3'b100, 32'hCAFEF00D, 1'b0);
`endif
    addr  = 32'h800;
    we    = 1'b1;
    wdata = 32'h55AA55AA;
    req   = 1'b1;
    step();
    chk("abort.sel1", 64'(sel_o), 64'b010);
    chk("abort.we1", 64'(we_o), 64'd0);
    step();
    reset = 1'b1;
    req   = 1'b0;
    step();
    chk_idle("abort.rst");
    chk("abort.addr_o", 64'(addr_o), 64'd0);
    chk("abort.wdata_o", 64'(wdata_o), 64'd0);
    chk("abort.rdata", 64'(rdata_o), 64'd0);
    chk("abort.err", 64'(err), 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle("abort.post");
    end
    addr = 32'h0;
    we   = 1'b0;
    req  = 1'b1;
    step();
    chk("b2b.sel_a", 64'(sel_o), 64'b001);
    addr = 32'h804;
    step();
    chk("b2b.ack_a", 64'(ack), 64'd1);
    chk("b2b.rdata_a", 64'(rdata_o), 64'hDEADBEEF);
    chk("b2b.addr_a", 64'(addr_o), 64'h0);
    step();
    chk_idle("b2b.gap");
    step();
    chk("b2b.sel_b1", 64'(sel_o), 64'b010);
    chk("b2b.ack_b1", 64'(ack), 64'd0);
    step();
    chk("b2b.sel_b2", 64'(sel_o), 64'b010);
    chk("b2b.ack_b2", 64'(ack), 64'd0);
    step();
    chk("b2b.ack_b", 64'(ack), 64'd1);
    chk("b2b.rdata_b", 64'(rdata_o), 64'h0BADF00D);
    chk("b2b.addr_b", 64'(addr_o), 64'h804);
    req = 1'b0;
    step();
    chk_idle("b2b.end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
